ring_arbiter: RTL and testbench

RING_ARBITER -- requirements
Module: ring_arbiter

---
 rtl/ring_arbiter.sv | 157 +++++++++++++++
 tb/tb_ring_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter.sv
// Four-requester round-robin arbiter with a rotating one-hot priority pointer.
// Optional tenure limit: define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles.
module ring_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [3:0] ptr,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic [3:0] r_ptr;
    logic [3:0] w_ptr_nxt;
    logic [3:0] w_pick;
    logic       r_grant_valid;
    logic       r_timeout;
    logic       w_timeout_nxt;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;
`endif

    if ((HOLD_MAX < 2) || (HOLD_MAX > 15)) begin : g_hold_range_check
        $error("ring_arbiter: HOLD_MAX must lie in 2..15");
    end

    function automatic logic [1:0] ptr_index(input logic [3:0] p);
        logic [1:0] idx;
        case (p)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // First set request at or above the pointer position; the 2-bit index wraps 3->0.
    function automatic logic [3:0] rr_pick(input logic [3:0] p, input logic [3:0] r);
        logic [3:0] g;
        logic [1:0] base;
        logic [1:0] idx;
        logic       found;
        g     = 4'b0000;
        found = 1'b0;
        base  = ptr_index(p);
        for (int k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
        return g;
    endfunction

    assign w_pick = rr_pick(r_ptr, req);

    // Next-state, next-grant and pointer update for the IDLE/BUSY machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                w_hold_nxt = 4'd0;
`endif
                if (enable && (req != 4'b0000)) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick;
                    w_ptr_nxt   = {w_pick[2:0], w_pick[3]};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if ((req & r_grant) == 4'b0000) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = 4'd0;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_grant_nxt   = 4'b0000;
                        w_timeout_nxt = 1'b1;
                        w_hold_nxt    = 4'd0;
                    end else begin
                        w_hold_nxt    = r_hold + 4'd1;
                    end
`else
                    w_state_nxt = ST_BUSY;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_ptr_nxt   = 4'b0001;
            end
        endcase
    end

    // State and output registers; clear (active low) overrides everything.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state       <= ST_IDLE;
            r_grant       <= 4'b0000;
            r_grant_valid <= 1'b0;
            r_ptr         <= 4'b0001;
            r_timeout     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold        <= 4'd0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_ptr         <= w_ptr_nxt;
            r_timeout     <= w_timeout_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold        <= w_hold_nxt;
`endif
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign ptr         = r_ptr;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed self-checking bench for ring_arbiter; follows ARB_TIMEOUT_EN with HOLD_MAX=4.
module tb_ring_arbiter;

    logic       clk;
    logic       clear;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [3:0] ptr;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    ring_arbiter #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .ptr         (ptr),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] p, input logic t);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".gv"}, 32'(grant_valid), 32'(g != 4'b0000));
        check_eq({tag, ".ptr"}, 32'(ptr), 32'(p));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_grant [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] rr_ptr   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        clear  = 1'b0;
        enable = 1'b0;
        req    = 4'b0000;
        tick();
        check_out("rst1", 4'b0000, 4'b0001, 1'b0);
        tick();
        check_out("rst2", 4'b0000, 4'b0001, 1'b0);
        clear  = 1'b1;
        enable = 1'b1;
        tick();
        check_out("idle0", 4'b0000, 4'b0001, 1'b0);
        tick();
        check_out("idle1", 4'b0000, 4'b0001, 1'b0);

        // Full round robin with all four requesting; each drops for one cycle after 3 grant cycles.
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("rr_first", rr_grant[i], rr_ptr[i], 1'b0);
            tick();
            tick();
            check_out("rr_third", rr_grant[i], rr_ptr[i], 1'b0);
            req = 4'b1111 & ~rr_grant[i];
            tick();
            check_out("rr_gap", 4'b0000, rr_ptr[i], 1'b0);
            req = 4'b1111;
        end
        tick();
        check_out("rr_wrap", 4'b0001, 4'b0010, 1'b0);
        req = 4'b0000;
        tick();
        check_out("rr_release", 4'b0000, 4'b0010, 1'b0);

        // Move ptr to 0100, then a wrap-around search picks requester 0.
        req = 4'b0010;
        tick();
        check_out("mv_ptr", 4'b0010, 4'b0100, 1'b0);
        req = 4'b0000;
        tick();
        check_out("mv_rel", 4'b0000, 4'b0100, 1'b0);
        req = 4'b0011;
        tick();
        check_out("wrap_pick", 4'b0001, 4'b0010, 1'b0);
        req = 4'b0000;
        tick();
        check_out("wrap_rel", 4'b0000, 4'b0010, 1'b0);

        // Bring ptr back to 0001 via requester 3.
        req = 4'b1000;
        tick();
        check_out("g3", 4'b1000, 4'b0001, 1'b0);
        req = 4'b0000;
        tick();
        check_out("g3_rel", 4'b0000, 4'b0001, 1'b0);

        // Enable low blocks new grants; raising it grants on the next edge.
        enable = 1'b0;
        req    = 4'b0101;
        tick();
        check_out("en_low1", 4'b0000, 4'b0001, 1'b0);
        tick();
        check_out("en_low2", 4'b0000, 4'b0001, 1'b0);
        enable = 1'b1;
        tick();
        check_out("en_high", 4'b0001, 4'b0010, 1'b0);

        // While busy, enable and other request bits are ignored.
        enable = 1'b0;
        req    = 4'b0111;
        tick();
        check_out("busy_ign", 4'b0001, 4'b0010, 1'b0);
        enable = 1'b1;
        req    = 4'b0000;
        tick();
        check_out("busy_rel", 4'b0000, 4'b0010, 1'b0);

        // A lone requester is re-granted after the idle cycle.
        req = 4'b0001;
        tick();
        check_out("regrant", 4'b0001, 4'b0010, 1'b0);
        req = 4'b0000;
        tick();
        check_out("regrant_rel", 4'b0000, 4'b0010, 1'b0);

        // Reset in the middle of a tenure.
        req = 4'b0100;
        tick();
        check_out("g2", 4'b0100, 4'b1000, 1'b0);
        tick();
        check_out("g2_hold", 4'b0100, 4'b1000, 1'b0);
        clear = 1'b0;
        tick();
        check_out("mid_rst", 4'b0000, 4'b0001, 1'b0);

        // Reset release with requests pending: grant one cycle later.
        clear = 1'b1;
        req   = 4'b0011;
        tick();
        check_out("post_rst", 4'b0001, 4'b0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
        repeat (3) begin
            tick();
            check_out("to_hold0", 4'b0001, 4'b0010, 1'b0);
        end
        tick();
        check_out("to_pulse0", 4'b0000, 4'b0010, 1'b1);
        tick();
        check_out("to_next", 4'b0010, 4'b0100, 1'b0);
        repeat (3) begin
            tick();
            check_out("to_hold1", 4'b0010, 4'b0100, 1'b0);
        end
        tick();
        check_out("to_pulse1", 4'b0000, 4'b0100, 1'b1);
        tick();
        check_out("to_again", 4'b0001, 4'b0010, 1'b0);
        repeat (3) begin
            tick();
            check_out("to_hold2", 4'b0001, 4'b0010, 1'b0);
        end
        // Release on the limit cycle is a normal release.
        req = 4'b0010;
        tick();
        check_out("limit_rel", 4'b0000, 4'b0010, 1'b0);
        tick();
        check_out("limit_next", 4'b0010, 4'b0100, 1'b0);
`else
        repeat (11) begin
            tick();
            check_out("hold_long", 4'b0001, 4'b0010, 1'b0);
        end
        req = 4'b0010;
        tick();
        check_out("long_rel", 4'b0000, 4'b0010, 1'b0);
        tick();
        check_out("long_next", 4'b0010, 4'b0100, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
